pio_step_sequencer: RTL and testbench

- Consumes the 17-bit output word of the Avalon PIO (`out_port`) and turns it into motor step/direction pulses.
- Bit 16 is a software toggle strobe. Bit 15 is direction. Bits 14:0 are the step count.
- Accepted commands are queued in a small FIFO and executed back-to-back by a pulse-timing FSM.
- `cmd_ack` and `status` are read back by software through an input PIO.

---
 rtl/pio_step_sequencer.sv | 178 +++++++++++++++++
 tb/tb_pio_step_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_step_sequencer.sv
// PIO-driven step/direction generator: toggle-strobed commands are queued in a
// small FIFO and played out as timed step pulses by a four-state engine.
module pio_step_sequencer #(
   parameter int FIFO_DEPTH  = 4,
   parameter int PULSE_HIGH  = 50,
   parameter int STEP_PERIOD = 1000,
   parameter int DIR_SETUP   = 10
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [16:0]                   cmd_in,
   output logic                          step_out,
   output logic                          dir_out,
   output logic                          cmd_ack,
   output logic                          busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int LOW_CYC = STEP_PERIOD - PULSE_HIGH;
   localparam int MAX_A   = (DIR_SETUP > PULSE_HIGH) ? DIR_SETUP : PULSE_HIGH;
   localparam int MAX_CYC = (MAX_A > LOW_CYC) ? MAX_A : LOW_CYC;
   localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
   localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(PULSE_HIGH - 1);
   localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [14:0]        rem_q, rem_d;
   logic               dir_q, dir_d;
   logic               step_q, step_d;
   logic               ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               ovf_q, ovf_d;
   logic               tog_q, tog_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [15:0]        mem_q [FIFO_DEPTH];

   logic        strobe, cnt_zero, abort, full, push, drop, pop_req, pop;
   logic [15:0] head;

   assign strobe   = cmd_in[16] ^ tog_q;
   assign cnt_zero = (cmd_in[14:0] == 15'd0);
   assign abort    = strobe && cnt_zero && cmd_in[15];
   assign full     = (level_q == LVL_W'(FIFO_DEPTH));
   // Fullness is judged on the registered level, so a same-cycle pop never frees a slot.
   assign push     = strobe && !cnt_zero && !full;
   assign drop     = strobe && !cnt_zero && full;
   assign pop      = pop_req && !abort;
   assign head     = mem_q[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      pop_req = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (level_q != '0) begin
               pop_req = 1'b1;
               rem_d   = head[14:0];
               dir_d   = head[15];
               cnt_d   = SETUP_LD;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = HIGH_LD;
               state_d = S_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_HIGH: begin
            if (cnt_q == '0) begin
               cnt_d   = LOW_LD;
               state_d = S_LOW;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_LOW: begin
            if (cnt_q == '0) begin
               rem_d = rem_q - 15'd1;
               if (rem_q > 15'd1) begin
                  cnt_d   = HIGH_LD;
                  state_d = S_HIGH;
               end else if (level_q != '0) begin
                  // Chain straight into the next move; SETUP covers any direction change.
                  pop_req = 1'b1;
                  rem_d   = head[14:0];
                  dir_d   = head[15];
                  cnt_d   = SETUP_LD;
                  state_d = S_SETUP;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = cnt_q;
         dir_d   = dir_q;
      end
   end

   always_comb begin
      tog_d    = cmd_in[16];
      ack_d    = ack_q ^ (strobe && !drop);
      ovf_d    = abort ? 1'b0 : (ovf_q | drop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
      step_d = (state_d == S_HIGH);
      busy_d = (state_d != S_IDLE) || (level_d != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         step_q   <= 1'b0;
         ack_q    <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         tog_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         step_q   <= step_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         tog_q    <= tog_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cmd_in[15:0];
   end

   assign step_out   = step_q;
   assign dir_out    = dir_q;
   assign cmd_ack    = ack_q;
   assign busy       = busy_q;
   assign overflow   = ovf_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_pio_step_sequencer.sv
// Bench for pio_step_sequencer: single-command vector table, overflow/abort,
// chained moves and mid-move reset, with expected step rises kept in a queue.
module tb_pio_step_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [16:0] cmd_in;
   logic        step_out, dir_out, cmd_ack, busy, overflow;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rise_cyc = 0;
   logic tog = 1'b0;
   logic exp_ack = 1'b0;
   logic skip_width = 1'b0;
   logic prev_step = 1'b0;
   logic [32:0] exp_q[$];
   logic [32:0] e;

   typedef struct {
      logic        dir;
      logic [14:0] cnt;
      int          n_pulses;
      logic [2:0]  exp_level;
      logic        exp_busy;
      logic        exp_dir;
   } vec_t;
   vec_t vecs[7];

   pio_step_sequencer #(
      .FIFO_DEPTH(4), .PULSE_HIGH(2), .STEP_PERIOD(5), .DIR_SETUP(1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cmd_in(cmd_in), .step_out(step_out),
      .dir_out(dir_out), .cmd_ack(cmd_ack), .busy(busy), .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) tick();
   endtask

   task automatic strobe(input logic d, input logic [14:0] n);
      tog = ~tog;
      cmd_in = {tog, d, n};
   endtask

   task automatic push_pulses(input int first, input int n, input logic d);
      for (int k = 0; k < n; k++) exp_q.push_back({d, 32'(first + 5 * k)});
   endtask

   // Every step rise must match the head of the expected queue in cycle and direction.
   always @(negedge clk) begin
      if (step_out && !prev_step) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rise actual cycle %0d required no rise", cyc);
         end else begin
            e = exp_q.pop_front();
            if (e[31:0] !== 32'(cyc) || e[32] !== dir_out) begin
               errors++;
               $display("FAIL rise_timing actual cycle %0d dir %0b required cycle %0d dir %0b",
                        cyc, dir_out, e[31:0], e[32]);
            end
         end
         rise_cyc = cyc;
      end
      if (!step_out && prev_step) begin
         if (!skip_width) chk("pulse_width", 32'(cyc - rise_cyc), 32'd2);
         skip_width = 1'b0;
      end
      prev_step = step_out;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int c;
      vecs[0] = '{dir: 1'b1, cnt: 15'd3, n_pulses: 3, exp_level: 3'd1, exp_busy: 1'b1, exp_dir: 1'b1};
      vecs[1] = '{dir: 1'b0, cnt: 15'd0, n_pulses: 0, exp_level: 3'd0, exp_busy: 1'b0, exp_dir: 1'b1};
      vecs[2] = '{dir: 1'b1, cnt: 15'd0, n_pulses: 0, exp_level: 3'd0, exp_busy: 1'b0, exp_dir: 1'b1};
      vecs[3] = '{dir: 1'b0, cnt: 15'd1, n_pulses: 1, exp_level: 3'd1, exp_busy: 1'b1, exp_dir: 1'b0};
      vecs[4] = '{dir: 1'b1, cnt: 15'd0, n_pulses: 0, exp_level: 3'd0, exp_busy: 1'b0, exp_dir: 1'b0};
      vecs[5] = '{dir: 1'b0, cnt: 15'd2, n_pulses: 2, exp_level: 3'd1, exp_busy: 1'b1, exp_dir: 1'b0};
      vecs[6] = '{dir: 1'b1, cnt: 15'd1, n_pulses: 1, exp_level: 3'd1, exp_busy: 1'b1, exp_dir: 1'b1};

      // Reset state, then a payload with bit 16 low must never strobe.
      reset_n = 1'b0;
      cmd_in  = 17'h0_0000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_step", step_out, 0);
      chk("rst_dir", dir_out, 0);
      chk("rst_ack", cmd_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_level", fifo_level, 0);
      reset_n = 1'b1;
      cmd_in  = 17'h0_8005;
      repeat (20) tick();
      chk("hold_ack", cmd_ack, 0);
      chk("hold_busy", busy, 0);
      chk("hold_level", fifo_level, 0);

      // Single commands on an idle engine.
      for (int i = 0; i < 7; i++) begin
         tick();
         c = cyc;
         strobe(vecs[i].dir, vecs[i].cnt);
         exp_ack = ~exp_ack;
         push_pulses(c + 3, vecs[i].n_pulses, vecs[i].dir);
         wait_until(c + 1);
         chk("vec_ack", cmd_ack, exp_ack);
         chk("vec_level", fifo_level, vecs[i].exp_level);
         chk("vec_busy", busy, vecs[i].exp_busy);
         chk("vec_ovf", overflow, 0);
         if (vecs[i].n_pulses > 0) begin
            wait_until(c + 2);
            chk("vec_dir_early", dir_out, vecs[i].dir);
            chk("vec_level_pop", fifo_level, 0);
            wait_until(c + 2 + 5 * vecs[i].n_pulses);
            chk("vec_busy_last_low", busy, 1);
            wait_until(c + 3 + 5 * vecs[i].n_pulses);
            chk("vec_busy_done", busy, 0);
         end else begin
            wait_until(c + 3);
            chk("vec_busy_idle", busy, 0);
         end
         chk("vec_step_done", step_out, 0);
         chk("vec_dir_final", dir_out, vecs[i].exp_dir);
      end

      // Six long moves four cycles apart: one executing, four queued, one dropped; then abort.
      tick();
      c = cyc;
      push_pulses(c + 3, 6, 1'b0);
      for (int i = 0; i < 6; i++) begin
         wait_until(c + 4 * i);
         strobe(1'b0, 15'd100);
         if (i < 5) exp_ack = ~exp_ack;
      end
      wait_until(c + 21);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_flag", overflow, 1);
      chk("ovf_ack", cmd_ack, exp_ack);
      chk("ovf_busy", busy, 1);
      wait_until(c + 28);
      skip_width = 1'b1;
      strobe(1'b1, 15'd0);
      exp_ack = ~exp_ack;
      wait_until(c + 29);
      chk("abort_step", step_out, 0);
      chk("abort_level", fifo_level, 0);
      chk("abort_ovf", overflow, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ack", cmd_ack, exp_ack);
      chk("abort_dir_hold", dir_out, 0);
      wait_until(c + 40);
      chk("abort_quiet", busy, 0);

      // Two chained moves with a direction change, no idle gap between them.
      tick();
      c = cyc;
      strobe(1'b0, 15'd2);
      exp_ack = ~exp_ack;
      push_pulses(c + 3, 2, 1'b0);
      tick();
      strobe(1'b1, 15'd2);
      exp_ack = ~exp_ack;
      push_pulses(c + 14, 2, 1'b1);
      wait_until(c + 2);
      chk("chain_level", fifo_level, 1);
      chk("chain_ack", cmd_ack, exp_ack);
      for (int k = 2; k < 24; k++) begin
         wait_until(c + k);
         chk("chain_busy", busy, 1);
         if (k == 12) chk("chain_dir_first", dir_out, 0);
         if (k == 13) chk("chain_dir_second", dir_out, 1);
         if (k == 13) chk("chain_setup_low", step_out, 0);
      end
      wait_until(c + 24);
      chk("chain_done", busy, 0);

      // Asynchronous reset in the middle of a step pulse.
      tick();
      c = cyc;
      strobe(1'b1, 15'd5);
      exp_ack = ~exp_ack;
      push_pulses(c + 3, 1, 1'b1);
      wait_until(c + 4);
      skip_width = 1'b1;
      #3 reset_n = 1'b0;
      #1;
      chk("arst_step", step_out, 0);
      chk("arst_dir", dir_out, 0);
      chk("arst_ack", cmd_ack, 0);
      chk("arst_busy", busy, 0);
      chk("arst_level", fifo_level, 0);
      cmd_in  = 17'h0_0000;
      tog     = 1'b0;
      exp_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (15) tick();
      chk("arst_quiet_busy", busy, 0);
      chk("arst_quiet_ack", cmd_ack, 0);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
